// File: rtl/multi_cycle_control.sv
// Multi-cycle sequencer for the 32-bit MIPS-subset datapath: FETCH/DECODE/EXEC/MEM/WB with memory stall, timeout and illegal-opcode traps.
// Optional performance counters (cycle_cnt, retired_cnt) are built when MC_PERF_CNT_EN is defined.
module multi_cycle_control #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic [3:0] state,
  output logic       halted,
  output logic       bus_err
`ifdef MC_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retired_cnt
`endif
);

  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEM_ADDR = 4'd2, S_MEM_RD = 4'd3,
    S_MEM_WB = 4'd4, S_MEM_WR = 4'd5, S_R_EXEC = 4'd6, S_R_WB = 4'd7,
    S_BRANCH = 4'd8, S_JUMP = 4'd9, S_I_EXEC = 4'd10, S_I_WB = 4'd11,
    S_HALT = 4'd12
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       bus_err_q, bus_err_d;
  logic       in_wait, timeout;

  // funct and zero are consumed by the datapath, not by the sequencer.
  logic unused_inputs;
  assign unused_inputs = ^{funct, zero};

  assign in_wait = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign timeout = in_wait && !mem_ready && (wait_cnt_q == 8'(MEM_WAIT_MAX));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= 8'd0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      bus_err_q  <= bus_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    state_d = mem_ready ? S_DECODE : (timeout ? S_HALT : S_FETCH);
      S_DECODE: begin
        case (opcode)
          6'b000000:            state_d = S_R_EXEC;
          6'b100011, 6'b101011: state_d = S_MEM_ADDR;
          6'b000100:            state_d = S_BRANCH;
          6'b000010:            state_d = S_JUMP;
          6'b001000:            state_d = S_I_EXEC;
          default:              state_d = S_HALT;
        endcase
      end
      S_MEM_ADDR: state_d = (opcode == 6'b101011) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   state_d = mem_ready ? S_MEM_WB : (timeout ? S_HALT : S_MEM_RD);
      S_MEM_WB:   state_d = S_FETCH;
      S_MEM_WR:   state_d = mem_ready ? S_FETCH : (timeout ? S_HALT : S_MEM_WR);
      S_R_EXEC:   state_d = S_R_WB;
      S_R_WB:     state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      S_I_EXEC:   state_d = S_I_WB;
      S_I_WB:     state_d = S_FETCH;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_HALT;
    endcase
    // The stall counter only survives a cycle that stays put waiting on memory.
    wait_cnt_d = (in_wait && !mem_ready && (state_d == state_q)) ? wait_cnt_q + 8'd1 : 8'd0;
    bus_err_d  = bus_err_q | timeout;
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    halted        = 1'b0;
    // Reset masks every output combinationally, without waiting for a clock.
    state         = rst ? state_q : 4'd0;
    bus_err       = rst & bus_err_q;
    if (rst) begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE:   alu_src_b = 2'b11;
        S_MEM_ADDR: begin alu_src_a = 1'b1; alu_src_b = 2'b10; end
        S_MEM_RD:   begin mem_read = 1'b1; iord = 1'b1; end
        S_MEM_WB:   begin reg_write = 1'b1; mem_to_reg = 1'b1; end
        S_MEM_WR:   begin mem_write = 1'b1; iord = 1'b1; end
        S_R_EXEC:   begin alu_src_a = 1'b1; alu_op = 2'b10; end
        S_R_WB:     begin reg_write = 1'b1; reg_dst = 1'b1; end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = 2'b01;
          pc_write_cond = 1'b1;
          pc_source     = 2'b01;
        end
        S_JUMP:     begin pc_write = 1'b1; pc_source = 2'b10; end
        S_I_EXEC:   begin alu_src_a = 1'b1; alu_src_b = 2'b10; end
        S_I_WB:     reg_write = 1'b1;
        S_HALT:     halted = 1'b1;
        default:    halted = 1'b0;
      endcase
    end
  end

`ifdef MC_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d, retired_cnt_q, retired_cnt_d;

  always_comb begin
    cycle_cnt_d   = (state_q != S_HALT) ? cycle_cnt_q + 1'b1 : cycle_cnt_q;
    retired_cnt_d = ((state_d == S_FETCH) && (state_q != S_FETCH)) ? retired_cnt_q + 1'b1
                                                                   : retired_cnt_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt_q   <= '0;
      retired_cnt_q <= '0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_d;
      retired_cnt_q <= retired_cnt_d;
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign retired_cnt = retired_cnt_q;
`endif

endmodule

// File: tb/tb_multi_cycle_control.sv
// Scoreboarded bench for multi_cycle_control: an instruction-level model expands each random
// instruction into its expected per-cycle control words; a negedge monitor pops and compares.
module tb_multi_cycle_control;
  localparam int MAX = 15;
  localparam int CNT_W = 32;
  localparam int W = 22;

  localparam int FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_RD = 3, MEM_WB = 4, MEM_WR = 5;
  localparam int R_EXEC = 6, R_WB = 7, BRANCH = 8, JUMP = 9, I_EXEC = 10, I_WB = 11, HALT = 12;
  localparam int K_R = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_J = 4, K_ADDI = 5, K_ILL = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] opcode = 6'd0, funct = 6'd0;
  logic       zero = 1'b0, mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, halted, bus_err;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;
`ifdef MC_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt, retired_cnt;
`endif

  logic [W-1:0] exp_q[$];
  logic [W-1:0] act_word;
  int checks = 0;
  int errors = 0;
  logic m_bus_err = 1'b0;

  multi_cycle_control #(.MEM_WAIT_MAX(MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .state(state), .halted(halted), .bus_err(bus_err)
`ifdef MC_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt)
`endif
  );

  // clock / reset / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  assign act_word = {state, halted, bus_err, pc_write, pc_write_cond, iord, mem_read, mem_write,
                     ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                     pc_source};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected control word for a state, straight from the per-state strobe table.
  function automatic logic [W-1:0] mk(input int st, input logic mr, input logic be);
    logic hl, pcw, pcwc, io, mrd, mwr, irw, m2r, rd, rw, asa;
    logic [1:0] asb, aop, pcs;
    {hl, pcw, pcwc, io, mrd, mwr, irw, m2r, rd, rw, asa} = '0;
    asb = 2'b00; aop = 2'b00; pcs = 2'b00;
    case (st)
      FETCH:    begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
      DECODE:   asb = 2'b11;
      MEM_ADDR: begin asa = 1; asb = 2'b10; end
      MEM_RD:   begin mrd = 1; io = 1; end
      MEM_WB:   begin rw = 1; m2r = 1; end
      MEM_WR:   begin mwr = 1; io = 1; end
      R_EXEC:   begin asa = 1; aop = 2'b10; end
      R_WB:     begin rw = 1; rd = 1; end
      BRANCH:   begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      JUMP:     begin pcw = 1; pcs = 2'b10; end
      I_EXEC:   begin asa = 1; asb = 2'b10; end
      I_WB:     rw = 1;
      default:  hl = 1;
    endcase
    return {4'(st), hl, be, pcw, pcwc, io, mrd, mwr, irw, m2r, rd, rw, asa, asb, aop, pcs};
  endfunction

  // monitor / scoreboard
  always @(negedge clk) begin
    if (exp_q.size() > 0) check("ctrl_word", 32'(act_word), 32'(exp_q.pop_front()));
  end

  // driver tasks: each step presents inputs for one cycle and queues that cycle's expectation
  task automatic step(input logic mr, input int st);
    mem_ready = mr;
    zero = 1'($urandom);
    funct = 6'($urandom);
    exp_q.push_back(mk(st, mr, m_bus_err));
    @(posedge clk); #1;
  endtask

  // Up to MAX stall cycles are tolerated; one more with memory still busy traps.
  task automatic wait_phase(input int st, input int stalls, output bit hung);
    hung = 0;
    if (stalls > MAX) begin
      for (int i = 0; i <= MAX; i++) step(1'b0, st);
      hung = 1;
      m_bus_err = 1'b1;
    end else begin
      for (int i = 0; i < stalls; i++) step(1'b0, st);
      step(1'b1, st);
    end
  endtask

  function automatic logic [5:0] op_of(input int kind);
    logic [5:0] op;
    case (kind)
      K_R: op = 6'b000000;  K_LW: op = 6'b100011;  K_SW: op = 6'b101011;
      K_BEQ: op = 6'b000100; K_J: op = 6'b000010;  K_ADDI: op = 6'b001000;
      default: begin
        do op = 6'($urandom);
        while (op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000});
      end
    endcase
    return op;
  endfunction

  task automatic run_instr(input int kind, input int fs, input int ms, output bit hung);
    opcode = op_of(kind);
    wait_phase(FETCH, fs, hung);
    if (hung) return;
    step(1'($urandom), DECODE);
    case (kind)
      K_R:    begin step(1'($urandom), R_EXEC); step(1'($urandom), R_WB); end
      K_LW: begin
        step(1'($urandom), MEM_ADDR);
        wait_phase(MEM_RD, ms, hung);
        if (!hung) step(1'($urandom), MEM_WB);
      end
      K_SW:   begin step(1'($urandom), MEM_ADDR); wait_phase(MEM_WR, ms, hung); end
      K_BEQ:  step(1'($urandom), BRANCH);
      K_J:    step(1'($urandom), JUMP);
      K_ADDI: begin step(1'($urandom), I_EXEC); step(1'($urandom), I_WB); end
      default: hung = 1;
    endcase
  endtask

  task automatic halt_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      opcode = 6'($urandom);
      step(1'($urandom), HALT);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("reset_mask", 32'(act_word), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    mem_ready = 1'b0;
    rst = 1'b1;
    m_bus_err = 1'b0;
`ifdef MC_PERF_CNT_EN
    check("cycle_cnt_reset", cycle_cnt, 0);
    check("retired_cnt_reset", retired_cnt, 0);
`endif
  endtask

  function automatic int rand_stalls();
    int r;
    r = $urandom_range(0, 19);
    if (r < 14) return r % 4;
    if (r < 17) return MAX;
    return MAX + 1;
  endfunction

  initial begin
    bit hung;
    do_reset();

    run_instr(K_R, 0, 0, hung);
`ifdef MC_PERF_CNT_EN
    check("cycle_cnt_rtype", cycle_cnt, 4);
    check("retired_cnt_rtype", retired_cnt, 1);
`endif
    run_instr(K_LW, 0, 3, hung);
    run_instr(K_BEQ, 1, 0, hung);
    run_instr(K_J, 0, 0, hung);
    run_instr(K_SW, 2, 2, hung);
    run_instr(K_ADDI, 0, 0, hung);
    run_instr(K_ADDI, MAX, 0, hung);
    run_instr(K_LW, 0, MAX, hung);
    run_instr(K_SW, 0, MAX, hung);

    run_instr(K_R, MAX + 1, 0, hung);
    halt_cycles(5);
    do_reset();

    opcode = 6'b111111;
    wait_phase(FETCH, 0, hung);
    step(1'b1, DECODE);
    halt_cycles(100);
    do_reset();

    run_instr(K_LW, 0, MAX + 1, hung);
    halt_cycles(3);
    do_reset();

    opcode = 6'b101011;
    wait_phase(FETCH, 0, hung);
    step(1'b1, DECODE);
    step(1'b0, MEM_ADDR);
    step(1'b0, MEM_WR);
    mem_ready = 1'b0;
    #1;
    check("mem_write_before_reset", 32'(mem_write), 32'd1);
    do_reset();
    check("state_after_release", 32'(state), 32'(FETCH));

    for (int n = 0; n < 60; n++) begin
      int kind;
      kind = ($urandom_range(0, 9) == 0) ? K_ILL : $urandom_range(0, 5);
      run_instr(kind, rand_stalls(), rand_stalls(), hung);
      if (hung) begin
        halt_cycles($urandom_range(1, 4));
        do_reset();
      end
    end

    @(negedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
